// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, HI/LO with multiplier and restoring divider,
// data SRAM request, forwarding and hazard outputs.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    ex_if_write_data,
    output logic [4:0]              ex_reg_id,
    output logic [31:0]             ex_write_data,
    output logic                    ex_is_load,
    output logic                    stallreq_for_ex
);
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    logic [ID_TO_EX_WD-1:0] bus_q;
    div_state_t             state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [31:0]            dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
    logic                   qneg_q, qneg_d, rneg_q, rneg_d;
    logic [31:0]            hi_q, hi_d, lo_q, lo_d;

    logic [31:0] pc, inst, rdata1, rdata2, src1, src2, alu_res, ex_result;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en, rf_we, sel_rf_res;
    logic [3:0]  ram_wen;
    logic [4:0]  rf_waddr;

    assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen, rf_we, rf_waddr,
            sel_rf_res, rdata1, rdata2} = bus_q;

    logic unused_bits;
    assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0]};

    // A stalled EX with a free MEM must emit a bubble rather than re-issue its instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    bus_q <= '0;
        else if (stall[2] && !stall[3]) bus_q <= '0;
        else if (!stall[2])          bus_q <= id_to_ex_bus;
    end

    logic [31:0] imm_sext, imm_zext;
    assign imm_sext = {{16{inst[15]}}, inst[15:0]};
    assign imm_zext = {16'b0, inst[15:0]};
    assign src1 = ({32{sel_src1[0]}} & rdata1) | ({32{sel_src1[1]}} & pc)
                | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
    assign src2 = ({32{sel_src2[0]}} & rdata2) | ({32{sel_src2[1]}} & imm_sext)
                | ({32{sel_src2[2]}} & 32'd8)  | ({32{sel_src2[3]}} & imm_zext);

    logic [4:0] sh;
    assign sh = src1[4:0];
    assign alu_res = ({32{alu_op[11]}} & (src1 + src2))
                   | ({32{alu_op[10]}} & (src1 - src2))
                   | ({32{alu_op[9]}}  & {31'b0, $signed(src1) < $signed(src2)})
                   | ({32{alu_op[8]}}  & {31'b0, src1 < src2})
                   | ({32{alu_op[7]}}  & (src1 & src2))
                   | ({32{alu_op[6]}}  & ~(src1 | src2))
                   | ({32{alu_op[5]}}  & (src1 | src2))
                   | ({32{alu_op[4]}}  & (src1 ^ src2))
                   | ({32{alu_op[3]}}  & (src2 << sh))
                   | ({32{alu_op[2]}}  & (src2 >> sh))
                   | ({32{alu_op[1]}}  & 32'($signed(src2) >>> sh))
                   | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});

    logic is_r, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_multu, is_div, is_divu;
    assign is_r     = inst[31:26] == 6'h00;
    assign is_mfhi  = is_r && inst[5:0] == 6'h10;
    assign is_mthi  = is_r && inst[5:0] == 6'h11;
    assign is_mflo  = is_r && inst[5:0] == 6'h12;
    assign is_mtlo  = is_r && inst[5:0] == 6'h13;
    assign is_mult  = is_r && inst[5:0] == 6'h18;
    assign is_multu = is_r && inst[5:0] == 6'h19;
    assign is_div   = is_r && inst[5:0] == 6'h1A;
    assign is_divu  = is_r && inst[5:0] == 6'h1B;

    logic [63:0] mul_s, mul_u;
    assign mul_s = {{32{rdata1[31]}}, rdata1} * {{32{rdata2[31]}}, rdata2};
    assign mul_u = {32'b0, rdata1} * {32'b0, rdata2};

    // Restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    logic [32:0] rem_sh;
    logic        rem_fits;
    assign rem_sh   = {rem_q, quo_q[31]};
    assign rem_fits = rem_sh >= {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            DIV_IDLE: if (is_div || is_divu) begin
                quo_d   = (is_div && rdata1[31]) ? -rdata1 : rdata1;
                dvs_d   = (is_div && rdata2[31]) ? -rdata2 : rdata2;
                rem_d   = '0;
                cnt_d   = '0;
                qneg_d  = is_div && (rdata1[31] ^ rdata2[31]);
                rneg_d  = is_div && rdata1[31];
                state_d = DIV_RUN;
            end
            DIV_RUN: begin
                rem_d = rem_fits ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
                quo_d = {quo_q[30:0], rem_fits};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = DIV_DONE;
            end
            DIV_DONE: if (!stall[2]) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    assign stallreq_for_ex = (state_q == DIV_RUN) || (state_q == DIV_IDLE && (is_div || is_divu));

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!stall[2]) begin
            if (is_mthi)  hi_d = rdata1;
            if (is_mtlo)  lo_d = rdata1;
            if (is_mult)  {hi_d, lo_d} = mul_s;
            if (is_multu) {hi_d, lo_d} = mul_u;
            if (state_q == DIV_DONE) begin
                hi_d = rneg_q ? -rem_q : rem_q;
                lo_d = qneg_q ? -quo_q : quo_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign ex_result = is_mfhi ? hi_q : is_mflo ? lo_q : alu_res;

    assign ex_to_mem_bus    = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
    assign data_sram_en     = ram_en;
    assign data_sram_wen    = ram_wen;
    assign data_sram_addr   = alu_res;
    assign data_sram_wdata  = rdata2;
    assign ex_if_write_data = rf_we;
    assign ex_reg_id        = rf_waddr;
    assign ex_write_data    = ex_result;
    assign ex_is_load       = rf_we & sel_rf_res;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage with directed vectors.
module tb_ex_stage;
    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   man_stall;
    logic [5:0]   stall;
    logic [158:0] id_bus;
    logic [75:0]  ex_to_mem_bus;
    logic         data_sram_en, ex_if_write_data, ex_is_load, stallreq_for_ex;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata, ex_write_data;
    logic [4:0]   ex_reg_id;

    always #5 clk = ~clk;

    // Control stalls IF..MEM-entry while the divider is busy.
    assign stall = man_stall | {2'b00, {4{stallreq_for_ex}}};

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_bus),
        .ex_to_mem_bus(ex_to_mem_bus), .data_sram_en(data_sram_en),
        .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .ex_if_write_data(ex_if_write_data),
        .ex_reg_id(ex_reg_id), .ex_write_data(ex_write_data), .ex_is_load(ex_is_load),
        .stallreq_for_ex(stallreq_for_ex)
    );

    localparam logic [11:0] ADD = 12'h800, SUB = 12'h400, SLT = 12'h200, SLTU = 12'h100,
                            AND = 12'h080, NOR = 12'h040, OR  = 12'h020, XOR  = 12'h010,
                            SLL = 12'h008, SRL = 12'h004, SRA = 12'h002, LUI  = 12'h001;

    typedef struct {
        logic [75:0] bus;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
            input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
            input logic ren, input logic [3:0] wen, input logic we, input logic [4:0] wa,
            input logic sel, input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, ren, wen, we, wa, sel, r1, r2};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] sa, input logic [5:0] funct);
        return {6'h00, 5'd1, 5'd2, 5'd3, sa, funct};
    endfunction

    task automatic issue(input string name, input logic [158:0] b, input logic [31:0] res);
        exp_t x;
        @(negedge clk);
        id_bus = b;
        x.bus   = {b[158:127], b[75], b[74:71], b[64], b[70], b[69:65], res};
        x.wdata = b[31:0];
        if (b[70] || b[75]) sb.push_back(x);
        @(negedge clk);
        chk({name, "_nostall"}, {75'b0, stallreq_for_ex}, 76'd0);
        id_bus = '0;
    endtask

    task automatic mf(input string name, input logic hi, input logic [31:0] exp);
        issue(name, mk(32'h0040_0000, {16'h0, 5'd8, 5'd0, hi ? 6'h10 : 6'h12}, 12'h0,
                       3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'h0, 32'h0), exp);
    endtask

    task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] q, input logic [31:0] r);
        int n;
        n = 0;
        @(negedge clk);
        id_bus = mk(32'h0040_0010, rtype(5'd0, sgn ? 6'h1A : 6'h1B), 12'h0, 3'b0, 4'b0,
                    1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, d);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            id_bus = '0;
            if (stallreq_for_ex) n++;
            else break;
        end
        chk({name, "_stall_cycles"}, 76'(n), 76'd33);
        mf({name, "_lo"}, 1'b0, q);
        mf({name, "_hi"}, 1'b1, r);
    endtask

    always @(negedge clk) begin
        if (rst && (ex_if_write_data || data_sram_en)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected nothing", ex_to_mem_bus);
            end else begin
                e = sb.pop_front();
                chk("ex_to_mem_bus", ex_to_mem_bus, e.bus);
                chk("forward", {38'b0, ex_if_write_data, ex_reg_id, ex_write_data},
                    {38'b0, e.bus[37], e.bus[36:32], e.bus[31:0]});
                chk("is_load", {75'b0, ex_is_load}, {75'b0, e.bus[37] & e.bus[38]});
                if (e.bus[43])
                    chk("sram", {7'b0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
                        {7'b0, 1'b1, e.bus[42:39], e.bus[31:0], e.wdata});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        man_stall = '0;
        id_bus = '0;
        repeat (2) @(negedge clk);
        chk("reset_bus", ex_to_mem_bus, 76'd0);
        chk("reset_side", {7'b0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
            76'd0);
        chk("reset_fwd", {33'b0, ex_if_write_data, ex_reg_id, ex_write_data, ex_is_load,
            stallreq_for_ex}, 76'd0);
        rst = 1'b1;

        issue("addiu", mk(32'hBFC0_0000, {6'h09, 5'd1, 5'd2, 16'hFFFF}, ADD, 3'b001, 4'b0010,
              1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h10, 32'h0), 32'h0000_000F);
        issue("jal", mk(32'hBFC0_0100, {6'h03, 26'h0}, ADD, 3'b010, 4'b0100,
              1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0), 32'hBFC0_0108);
        issue("subu", mk(32'h100, rtype(0, 6'h23), SUB, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1,
              5'd3, 1'b0, 32'd5, 32'd7), 32'hFFFF_FFFE);
        issue("slt", mk(32'h104, rtype(0, 6'h2A), SLT, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1,
              5'd3, 1'b0, 32'hFFFF_FFFF, 32'd1), 32'd1);
        issue("sltu", mk(32'h108, rtype(0, 6'h2B), SLTU, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1,
              5'd3, 1'b0, 32'hFFFF_FFFF, 32'd1), 32'd0);
        issue("and", mk(32'h10C, rtype(0, 6'h24), AND, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1,
              5'd3, 1'b0, 32'hFFFF_0F0F, 32'h0000_FFFF), 32'h0000_0F0F);
        issue("nor", mk(32'h110, rtype(0, 6'h27), NOR, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1,
              5'd3, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000), 32'h0000_0F0F);
        issue("ori", mk(32'h114, {6'h0D, 5'd1, 5'd2, 16'h8001}, OR, 3'b001, 4'b1000, 1'b0,
              4'h0, 1'b1, 5'd2, 1'b0, 32'h1234_0000, 32'h0), 32'h1234_8001);
        issue("xor", mk(32'h118, rtype(0, 6'h26), XOR, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1,
              5'd3, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0), 32'hF0F0_F0F0);
        issue("sll", mk(32'h11C, rtype(5'd4, 6'h00), SLL, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1,
              5'd3, 1'b0, 32'h0, 32'h0000_00F1), 32'h0000_0F10);
        issue("srlv", mk(32'h120, rtype(0, 6'h06), SRL, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1,
              5'd3, 1'b0, 32'h24, 32'h8000_0000), 32'h0800_0000);
        issue("sra", mk(32'h124, rtype(5'd4, 6'h03), SRA, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1,
              5'd3, 1'b0, 32'h0, 32'h8000_0000), 32'hF800_0000);
        issue("lui", mk(32'h128, {6'h0F, 5'd0, 5'd3, 16'h1234}, LUI, 3'b000, 4'b1000, 1'b0,
              4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0), 32'h1234_0000);
        issue("sw", mk(32'h12C, {6'h2B, 5'd1, 5'd2, 16'hFFFC}, ADD, 3'b001, 4'b0010, 1'b1,
              4'hF, 1'b0, 5'd2, 1'b0, 32'h1000, 32'hDEAD_BEEF), 32'h0000_0FFC);
        issue("lw", mk(32'h130, {6'h23, 5'd1, 5'd5, 16'h0008}, ADD, 3'b001, 4'b0010, 1'b1,
              4'h0, 1'b1, 5'd5, 1'b1, 32'h2000, 32'h0), 32'h0000_2008);

        issue("mult", mk(32'h134, rtype(0, 6'h18), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0,
              1'b0, 32'hFFFF_FFFF, 32'd3), 32'h0);
        mf("mult_hi", 1'b1, 32'hFFFF_FFFF);
        mf("mult_lo", 1'b0, 32'hFFFF_FFFD);
        issue("multu", mk(32'h138, rtype(0, 6'h19), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0,
              1'b0, 32'hFFFF_FFFF, 32'd3), 32'h0);
        mf("multu_hi", 1'b1, 32'd2);
        mf("multu_lo", 1'b0, 32'hFFFF_FFFD);
        issue("mthi", mk(32'h13C, rtype(0, 6'h11), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0,
              1'b0, 32'hCAFE_0001, 32'h0), 32'h0);
        mf("mthi_hi", 1'b1, 32'hCAFE_0001);

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

        // Bubble: EX stalled while MEM runs, with a live instruction waiting upstream.
        issue("pre_bubble", mk(32'h140, {6'h09, 5'd1, 5'd2, 16'h0001}, ADD, 3'b001, 4'b0010,
              1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h1, 32'h0), 32'h2);
        @(negedge clk);
        man_stall = 6'b000111;
        id_bus = mk(32'h144, {6'h09, 5'd1, 5'd2, 16'h0001}, ADD, 3'b001, 4'b0010,
                    1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h5, 32'h0);
        @(negedge clk);
        chk("bubble_bus", ex_to_mem_bus, 76'd0);
        chk("bubble_fwd", {75'b0, ex_if_write_data}, 76'd0);
        man_stall = '0;
        id_bus = '0;

        // Reset in the middle of a division.
        @(negedge clk);
        id_bus = mk(32'h148, rtype(0, 6'h1B), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0,
                    1'b0, 32'd100, 32'd7);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            id_bus = '0;
        end
        chk("run_stall_before_rst", {75'b0, stallreq_for_ex}, 76'd1);
        rst = 1'b0;
        #1;
        chk("rst_stall_drop", {75'b0, stallreq_for_ex}, 76'd0);
        chk("rst_bus", ex_to_mem_bus, 76'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {75'b0, stallreq_for_ex}, 76'd0);
        mf("post_rst_hi", 1'b1, 32'h0);
        mf("post_rst_lo", 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 76'(sb.size()), 76'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
